// File: rtl/sevenseg_decoder_if.sv
// rtl/sevenseg_decoder_if.sv - display bus and per-slot readback signals of the seven-segment decoder
// Macro SEVENSEG_DP_EN adds the decimal point line dp_n and per-slot dp readback.
// Signals:
//   seg_n   [6:0]          segment lines, active low, bit0=a .. bit6=g
//   dig_n   [DIGITS-1:0]   digit selects, active low
//   dp_n                   decimal point line, active low (SEVENSEG_DP_EN only)
//   value   [4*DIGITS-1:0] decoded nibble per slot
//   blank/minus/bad        per-slot glyph class flags
//   dp      [DIGITS-1:0]   per-slot decimal point (SEVENSEG_DP_EN only)
//   upd/upd_idx            slot write pulse and its index
//   frame/collide          all-slots-seen pulse, multi-select pulse
// Modports: master drives the display bus, slave is the decoder.
interface sevenseg_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   dig_n;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   minus;
    logic [DIGITS-1:0]   bad;
    logic                upd;
    logic [2:0]          upd_idx;
    logic                frame;
    logic                collide;
`ifdef SEVENSEG_DP_EN
    logic                dp_n;
    logic [DIGITS-1:0]   dp;

    modport master (
        output seg_n, dig_n, dp_n,
        input  value, blank, minus, bad, dp, upd, upd_idx, frame, collide
    );
    modport slave (
        input  seg_n, dig_n, dp_n,
        output value, blank, minus, bad, dp, upd, upd_idx, frame, collide
    );
`else
    modport master (
        output seg_n, dig_n,
        input  value, blank, minus, bad, upd, upd_idx, frame, collide
    );
    modport slave (
        input  seg_n, dig_n,
        output value, blank, minus, bad, upd, upd_idx, frame, collide
    );
`endif
endinterface

// File: rtl/sevenseg_decoder.sv
// rtl/sevenseg_decoder.sv - reconstructs per-digit glyphs from a multiplexed active-low seven-segment bus
// Macro SEVENSEG_DP_EN adds decimal point capture (bus.dp_n in, bus.dp out).
// Ports:
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      sevenseg_decoder_if.slave: seg_n/dig_n(/dp_n) in; value, blank, minus, bad(, dp),
//            upd, upd_idx, frame, collide out
// Parameters: DIGITS (1..8) digit positions, STABLE (>=1) hold cycles before capture.
module sevenseg_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    sevenseg_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
`ifdef SEVENSEG_DP_EN
    localparam int SW = DIGITS + 8;
`else
    localparam int SW = DIGITS + 7;
`endif

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Raw bus packed as {[dp_n,] dig_n, seg_n}; all ones is the idle display.
    logic [SW-1:0]       w_raw;
    logic [SW-1:0]       r_sync1;
    logic [SW-1:0]       r_sync2;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    state_t              r_state;
    state_t              w_state_next;
    logic                w_capture;

    logic [6:0]          w_pat;
    logic [DIGITS-1:0]   w_sel;
    logic                w_onehot;
    logic                w_multi;
    logic [2:0]          w_idx;
    logic [3:0]          w_nib;
    logic                w_is_blank;
    logic                w_is_minus;
    logic                w_is_bad;
    logic [DIGITS-1:0]   w_seen_set;

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_minus;
    logic [DIGITS-1:0]   r_bad;
    logic [DIGITS-1:0]   r_seen;
    logic                r_upd;
    logic [2:0]          r_upd_idx;
    logic                r_frame;
    logic                r_collide;

`ifdef SEVENSEG_DP_EN
    logic [DIGITS-1:0]   r_dp;
    assign w_raw  = {bus.dp_n, bus.dig_n, bus.seg_n};
    assign bus.dp = r_dp;
`else
    assign w_raw  = {bus.dig_n, bus.seg_n};
`endif

    assign w_pat = ~r_sync2[6:0];
    assign w_sel = ~r_sync2[7 +: DIGITS];

    // Stability counter and lock FSM: the first-stage flop is the value the
    // sample is about to take, so a mismatch means the sample changes now.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_cnt   <= '0;
            r_state <= SETTLE;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (r_sync1 != r_sync2) begin
            w_cnt_next = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CW'(1);
        end
        w_state_next = (w_cnt_next == CNT_MAX) ? LOCKED : SETTLE;
        // Capture only on entry to LOCKED so a held pattern is taken once.
        w_capture    = (r_state == SETTLE) && (w_state_next == LOCKED);
    end

    // Select classification: exactly one low is a scan slot, several is a collision.
    always_comb begin
        w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
        w_multi  = (w_sel != '0) && !w_onehot;
        w_idx    = 3'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_sel[k]) w_idx = 3'(k);
        end
        w_seen_set = r_seen | w_sel;
    end

    // Glyph table; anything not listed is flagged bad with a zero nibble.
    always_comb begin
        w_nib      = 4'h0;
        w_is_blank = 1'b0;
        w_is_minus = 1'b0;
        w_is_bad   = 1'b0;
        case (w_pat)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            7'h00: w_is_blank = 1'b1;
            7'h40: w_is_minus = 1'b1;
            default: w_is_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value   <= '0;
            r_blank   <= '1;
            r_minus   <= '0;
            r_bad     <= '0;
            r_seen    <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= 3'd0;
            r_frame   <= 1'b0;
            r_collide <= 1'b0;
`ifdef SEVENSEG_DP_EN
            r_dp      <= '0;
`endif
        end else begin
            r_upd     <= 1'b0;
            r_frame   <= 1'b0;
            r_collide <= 1'b0;
            if (w_capture && w_onehot) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (w_sel[k]) begin
                        r_value[4*k +: 4] <= w_nib;
                        r_blank[k]        <= w_is_blank;
                        r_minus[k]        <= w_is_minus;
                        r_bad[k]          <= w_is_bad;
`ifdef SEVENSEG_DP_EN
                        r_dp[k]           <= ~r_sync2[SW-1];
`endif
                    end
                end
                r_upd     <= 1'b1;
                r_upd_idx <= w_idx;
                if (&w_seen_set) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen  <= w_seen_set;
                end
            end else if (w_capture && w_multi) begin
                r_collide <= 1'b1;
            end
        end
    end

    assign bus.value   = r_value;
    assign bus.blank   = r_blank;
    assign bus.minus   = r_minus;
    assign bus.bad     = r_bad;
    assign bus.upd     = r_upd;
    assign bus.upd_idx = r_upd_idx;
    assign bus.frame   = r_frame;
    assign bus.collide = r_collide;
endmodule
